// File: rtl/button_repeat_ctrl.sv
// Multi-channel pushbutton front end: symmetric debounce, press/click/auto-repeat pulses, chord lockout.
// Optional BTN_SYNC_EN places a 2-flop synchronizer ahead of the debouncer; `evt` is the press|rpt strobe.
`timescale 1ns/1ps

module button_repeat_ctrl #(
    parameter int N_BTN            = 4,
    parameter int CLK_HZ           = 50_000_000,
    parameter int DEBOUNCE_MS      = 20,
    parameter int REPEAT_DELAY_MS  = 500,
    parameter int REPEAT_PERIOD_MS = 200,
    parameter int ACTIVE_LOW       = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] held,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] click,
    output logic [N_BTN-1:0] rpt,
    output logic [N_BTN-1:0] evt
);

    localparam int MS_TICKS = CLK_HZ / 1000;
    localparam int DB       = DEBOUNCE_MS * MS_TICKS;
    localparam int RD       = REPEAT_DELAY_MS * MS_TICKS;
    localparam int RP       = REPEAT_PERIOD_MS * MS_TICKS;
    localparam int MAX_DR   = (DB > RD) ? DB : RD;
    localparam int MAX_T    = (MAX_DR > RP) ? MAX_DR : RP;
    localparam int CW       = $clog2(MAX_T + 1);

    localparam logic [CW-1:0]    DB_LAST = CW'(DB - 1);
    localparam logic [CW-1:0]    RD_C    = CW'(RD);
    localparam logic [CW-1:0]    RP_C    = CW'(RP);
    localparam logic [CW-1:0]    CNT_ONE = CW'(1);
    localparam logic [N_BTN-1:0] POL     = (ACTIVE_LOW != 0) ? {N_BTN{1'b1}} : {N_BTN{1'b0}};

    // p is the normalised level: 1 always means pressed
    logic [N_BTN-1:0] p_raw;
    logic [N_BTN-1:0] p;

    assign p_raw = btn_raw ^ POL;

`ifdef BTN_SYNC_EN
    logic [N_BTN-1:0] sync1_q, sync1_d;
    logic [N_BTN-1:0] sync2_q, sync2_d;

    assign sync1_d = p_raw;
    assign sync2_d = sync1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign p = sync2_q;
`else
    assign p = p_raw;
`endif

    logic [N_BTN-1:0] held_q, held_d;
    logic [N_BTN-1:0] press_q, press_d;
    logic [N_BTN-1:0] click_q, click_d;
    logic [N_BTN-1:0] rpt_q, rpt_d;
    logic [N_BTN-1:0] evt_q, evt_d;
    logic [N_BTN-1:0] long_q, long_d;
    logic [N_BTN-1:0] phase_q, phase_d;
    logic [CW-1:0]    dbc_q [N_BTN];
    logic [CW-1:0]    dbc_d [N_BTN];
    logic [CW-1:0]    rc_q  [N_BTN];
    logic [CW-1:0]    rc_d  [N_BTN];
    logic             chord_q, chord_d, chord_any;
    logic [CW-1:0]    rc_tgt;

    function automatic logic multi_hot(input logic [N_BTN-1:0] v);
        int cnt;
        cnt = 0;
        for (int i = 0; i < N_BTN; i++) begin
            cnt += int'(v[i]);
        end
        return cnt > 1;
    endfunction

    // Debounce: the counter only advances while the input disagrees with held
    always_comb begin
        held_d = held_q;
        for (int i = 0; i < N_BTN; i++) begin
            dbc_d[i] = '0;
            if (p[i] != held_q[i]) begin
                if (dbc_q[i] == DB_LAST) begin
                    held_d[i] = ~held_q[i];
                end else begin
                    dbc_d[i] = dbc_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Chord is checked on both sides of the edge so a chord entering or leaving
    // this cycle still blocks repeats and restarts the full delay afterwards.
    always_comb begin
        chord_q   = multi_hot(held_q);
        chord_d   = multi_hot(held_d);
        chord_any = chord_q | chord_d;
        rpt_d     = '0;
        phase_d   = '0;
        rc_tgt    = RD_C;
        for (int i = 0; i < N_BTN; i++) begin
            rc_d[i] = '0;
            if (held_q[i] && held_d[i] && !chord_any) begin
                rc_tgt     = phase_q[i] ? RP_C : RD_C;
                phase_d[i] = phase_q[i];
                if ((rc_q[i] + CNT_ONE) >= rc_tgt) begin
                    rpt_d[i]   = 1'b1;
                    phase_d[i] = 1'b1;
                end else begin
                    rc_d[i] = rc_q[i] + CNT_ONE;
                end
            end
        end
        press_d = held_d & ~held_q;
        click_d = held_q & ~held_d & ~long_q;
        long_d  = held_d & (long_q | rpt_d | {N_BTN{chord_d}});
        evt_d   = press_d | rpt_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_q  <= '0;
            press_q <= '0;
            click_q <= '0;
            rpt_q   <= '0;
            evt_q   <= '0;
            long_q  <= '0;
            phase_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                dbc_q[i] <= '0;
                rc_q[i]  <= '0;
            end
        end else begin
            held_q  <= held_d;
            press_q <= press_d;
            click_q <= click_d;
            rpt_q   <= rpt_d;
            evt_q   <= evt_d;
            long_q  <= long_d;
            phase_q <= phase_d;
            for (int i = 0; i < N_BTN; i++) begin
                dbc_q[i] <= dbc_d[i];
                rc_q[i]  <= rc_d[i];
            end
        end
    end

    assign held  = held_q;
    assign press = press_q;
    assign click = click_q;
    assign rpt   = rpt_q;
    assign evt   = evt_q;

endmodule

// File: tb/tb_button_repeat_ctrl.sv
// Table-driven bench for button_repeat_ctrl with 1 ms = 1 cycle, DB=4, RD=20, RP=10, active-low keys.
`timescale 1ns/1ps

module tb_button_repeat_ctrl;

    localparam int N  = 4;
    localparam int VW = 5 * N;
`ifdef BTN_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] btn_raw;
    logic [N-1:0] held, press, click, rpt, evt;

    always #5 clk = ~clk;

    button_repeat_ctrl #(
        .N_BTN(N), .CLK_HZ(1000), .DEBOUNCE_MS(4), .REPEAT_DELAY_MS(20),
        .REPEAT_PERIOD_MS(10), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .held(held),
        .press(press), .click(click), .rpt(rpt), .evt(evt)
    );

    typedef enum int {K_RAW, K_HELD, K_PRESS, K_CLICK, K_RPT} kind_e;
    typedef struct {
        kind_e kind;
        int    ch;
        int    a;
        int    b;
    } vec_t;

    vec_t           tbl[$];
    logic [VW-1:0]  exp_q[$];
    int             checks   = 0;
    int             failures = 0;

    function automatic void add(kind_e k, int ch, int a, int b);
        vec_t v;
        v.kind = k; v.ch = ch; v.a = a; v.b = b;
        tbl.push_back(v);
    endfunction

    // RAW: pressed for cycles a..b; HELD: high for a <= c < b; pulses at cycle a
    function automatic logic [N-1:0] raw_at(int c);
        logic [N-1:0] r;
        r = '0;
        foreach (tbl[j]) begin
            if (tbl[j].kind == K_RAW && c >= tbl[j].a && c <= tbl[j].b) r[tbl[j].ch] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] exp_at(int c);
        logic [N-1:0] h, p, k, r;
        h = '0; p = '0; k = '0; r = '0;
        foreach (tbl[j]) begin
            case (tbl[j].kind)
                K_HELD:  if (c >= tbl[j].a + L && c < tbl[j].b + L) h[tbl[j].ch] = 1'b1;
                K_PRESS: if (c == tbl[j].a + L) p[tbl[j].ch] = 1'b1;
                K_CLICK: if (c == tbl[j].a + L) k[tbl[j].ch] = 1'b1;
                K_RPT:   if (c == tbl[j].a + L) r[tbl[j].ch] = 1'b1;
                default: ;
            endcase
        end
        return {h, p, k, r, p | r};
    endfunction

    task automatic step(input string name, input int c, input logic [VW-1:0] e);
        logic [VW-1:0] got;
        logic [VW-1:0] want;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        got  = {held, press, click, rpt, evt};
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d got{held,press,click,rpt,evt}=%h exp=%h", name, c, got, want);
        end
    endtask

    task automatic run(input string name, input int len);
        for (int c = 1; c <= len; c++) begin
            btn_raw = ~raw_at(c);
            step(name, c, exp_at(c));
        end
    endtask

    task automatic check_zero(input string name);
        logic [VW-1:0] got;
        got = {held, press, click, rpt, evt};
        checks++;
        if (got !== '0) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, {VW{1'b0}});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        btn_raw = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        tbl.delete();
        run("idle", 5);

        // Bounces of 3 cycles never reach the 4-cycle window
        tbl.delete();
        add(K_RAW, 0, 1, 3);
        add(K_RAW, 0, 5, 7);
        run("bounce", 20);

        tbl.delete();
        add(K_RAW, 0, 1, 12);
        add(K_HELD, 0, 4, 16);
        add(K_PRESS, 0, 4, 0);
        add(K_CLICK, 0, 16, 0);
        run("short_press", 30);

        tbl.delete();
        add(K_RAW, 1, 1, 50);
        add(K_HELD, 1, 4, 54);
        add(K_PRESS, 1, 4, 0);
        add(K_RPT, 1, 24, 0);
        add(K_RPT, 1, 34, 0);
        add(K_RPT, 1, 44, 0);
        run("long_hold", 70);

        // ch2 held fall at 46 restarts ch0's full 20-cycle delay
        tbl.delete();
        add(K_RAW, 0, 1, 80);
        add(K_RAW, 2, 3, 42);
        add(K_HELD, 0, 4, 84);
        add(K_HELD, 2, 6, 46);
        add(K_PRESS, 0, 4, 0);
        add(K_PRESS, 2, 6, 0);
        add(K_RPT, 0, 66, 0);
        add(K_RPT, 0, 76, 0);
        run("chord", 100);

        tbl.delete();
        add(K_RAW, 3, 1, 1000);
        add(K_HELD, 3, 4, 1000);
        add(K_PRESS, 3, 4, 0);
        add(K_RPT, 3, 24, 0);
        run("pre_reset", 28);

        rst_n = 1'b0;
        #1;
        check_zero("rst_async");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("rst_hold");
        rst_n = 1'b1;

        // Still pressed across reset: debounced from scratch, no click on release
        tbl.delete();
        add(K_RAW, 3, 1, 26);
        add(K_HELD, 3, 4, 30);
        add(K_PRESS, 3, 4, 0);
        add(K_RPT, 3, 24, 0);
        run("post_reset", 45);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
